i2c_slave_regbank: RTL and testbench
====================================

Name: i2c_slave_regbank

Overview:
- Next-generation I2C slave that replaces the single-byte write-only slave with a parametrised bank of NUM_BYTES registers behind a register pointer.
- Supports write and read transfers, pointer auto-increment with wrap-around, repeated START, and glitch-filtered SCL/SDA oversampled on a system clock.
- Sits between the board I2C bus (SDA pulled up externally) and the CPLD parallel I/O.

Parameters:
- NUM_BYTES, 4, number of 8-bit registers (1..16).
- PTR_W, 4, pointer width; must satisfy 2**PTR_W >= NUM_BYTES.
- FILTER_LEN, 3, consecutive equal samples needed before a filtered SCL/SDA level changes (1..7).

Ports:
- clk  input  1  system clock, at least 10x the SCL rate.
- reset  input  1  asynchronous, active-low reset.
- SCL  input  1  I2C clock from master.
- SDA  inout  1  I2C data; open-drain, drives 0 or Z only.
- ADR  input  7  slave address.
- IOin  input  8*NUM_BYTES  read-back sources; byte k is IOin[8k+7:8k].
- IOout  output  8*NUM_BYTES  written registers; byte k is IOout[8k+7:8k].
- wr_strobe  output  1  one-clk pulse for each committed write byte.
- wr_index  output  PTR_W  register index of the last committed write.
- busy  output  1  high from an addressed START to STOP, or until the return to IDLE.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, IOout=0, pointer=0, wr_strobe=0, wr_index=0, busy=0.
  - SDA released (Z).
  - All of this holds for any reset mid-transfer.
- Input conditioning:
  - 2-FF synchroniser, then the FILTER_LEN filter on SCL and SDA.
  - Edges are detected on the filtered signals.
  - Bus event latency: 2+FILTER_LEN clk.
- Bus conditions:
  - START / repeated START: filtered SDA falls while SCL is high. From any state go to ADDR and clear the bit count.
  - STOP: filtered SDA rises while SCL is high. From any state go to IDLE, release SDA, busy=0.
- Timing rules:
  - Bits are sampled on filtered SCL rising.
  - SDA drive changes only in the clk after filtered SCL falling.
- States:
  - IDLE: wait for START.
  - ADDR: shift 7 address bits plus R/W.
    - Address match → ADDR_ACK.
    - Mismatch → IDLE, no ACK, SDA stays released.
  - ADDR_ACK: drive SDA=0 for the 9th bit; busy=1.
    - W → PTR.
    - R → RDATA; load the shift register from IOin[pointer].
  - PTR: shift 8 bits.
    - Value < NUM_BYTES → PTR_ACK; pointer is loaded.
    - Value ≥ NUM_BYTES → NACK (SDA released), then IDLE; pointer unchanged.
  - PTR_ACK → WDATA.
  - WDATA: shift 8 bits, then go to WDATA_ACK.
    - Byte commit occurs one clk after the 8th SCL rising.
    - At commit: IOout[pointer] = byte, wr_index = pointer, wr_strobe pulses for 1 clk.
  - WDATA_ACK: drive ACK, then increment the pointer and return to WDATA.
  - RDATA: drive MSB first; one bit per SCL low phase.
  - RDATA_ACK: release SDA and sample the master's bit on SCL rising.
    - ACK (0): increment the pointer, load IOin[pointer], → RDATA.
    - NACK (1): → IDLE, SDA released.
- Pointer:
  - Increment wraps NUM_BYTES-1 → 0.
  - The pointer persists across transfers, so a read without a pointer phase uses the current pointer.
- Simultaneous events: a START or STOP detected in the same clk as an SCL edge takes priority over bit processing.
- A partially shifted write byte is discarded on START, STOP or reset; IOout is unchanged.
- An address match uses all 7 bits. The general-call address (0x00) is not acknowledged unless ADR=0.

Test Plan:
- ADR=7'h10: S, 0x20, ptr 0x00, 0x8E, P → three ACKs, IOout[7:0]=8'h8E, one wr_strobe with wr_index=0, busy low after P.
- Address mismatch: S, 0x2E (7'h17 W), 0x22, P → SDA never driven low, IOout unchanged, busy=0 throughout.
- Burst with wrap (NUM_BYTES=4): S, 0x20, ptr 0x03, then 0xA1 0xB2 0xC3, P → IOout = {8'hA1 in byte 3, 8'hB2 in byte 0, 8'hC3 in byte 1}, four ACKs after the address, three strobes.
- Combined read: IOin = 32'h44332211; S, 0x20, ptr 0x01, Sr, 0x21, then master ACK, ACK, NACK, P → bench receives 0x22, 0x33, 0x44; pointer = 3 afterwards.
- Pointer out of range: S, 0x20, ptr 0x05 → 9th bit NACK (SDA high), state IDLE, and a following data byte is not acknowledged.
- Robustness:
  - Apply a 1-clk SCL glitch mid-bit → ignored.
  - Assert reset mid-WDATA after 4 bits → SDA released, IOout=0.
  - A subsequent full write of 0x5A to ptr 2 succeeds.

Source files
------------

// File: rtl/i2c_slave_regbank.sv
// rtl/i2c_slave_regbank.sv - I2C slave exposing a pointer-addressed bank of 8-bit registers
// Oversampled, glitch-filtered SCL/SDA; write, read, auto-increment with wrap, repeated START.

module i2c_slave_regbank_filt #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);
  localparam logic [2:0] LAST = 3'(FILTER_LEN - 1);

  logic       s1_q, s2_q, f_q, f_d;
  logic [2:0] cnt_q, cnt_d;

  // The filtered level only flips once the synchronised input disagreed FILTER_LEN times in a row.
  always_comb begin
    f_d   = f_q;
    cnt_d = 3'd0;
    if (s2_q != f_q) begin
      if (cnt_q == LAST) f_d = s2_q;
      else               cnt_d = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q  <= 1'b1;
      s2_q  <= 1'b1;
      f_q   <= 1'b1;
      cnt_q <= 3'd0;
    end else begin
      s1_q  <= din;
      s2_q  <= s1_q;
      f_q   <= f_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout = f_q;
endmodule

module i2c_slave_regbank #(
  parameter int NUM_BYTES  = 4,
  parameter int PTR_W      = 4,
  parameter int FILTER_LEN = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   SCL,
  inout  wire                    SDA,
  input  logic [6:0]             ADR,
  input  logic [8*NUM_BYTES-1:0] IOin,
  output logic [8*NUM_BYTES-1:0] IOout,
  output logic                   wr_strobe,
  output logic [PTR_W-1:0]       wr_index,
  output logic                   busy
);
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  state_t                 state_q, state_d;
  logic [7:0]             sr_q, sr_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d, ptr_inc;
  logic                   sda_oe_q, sda_oe_d, phase_q, phase_d, rw_q, rw_d;
  logic                   commit_q, commit_d, strobe_q, strobe_d, busy_q, busy_d;
  logic [8*NUM_BYTES-1:0] io_q, io_d;
  logic [PTR_W-1:0]       idx_q, idx_d;
  logic                   scl_f, sda_f, scl_p_q, sda_p_q;
  logic                   scl_rise, scl_fall, start, stop;
  logic [7:0]             shifted, rd_byte, rd_byte_inc;

  i2c_slave_regbank_filt #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk(clk), .reset(reset), .din(SCL), .dout(scl_f));
  i2c_slave_regbank_filt #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk(clk), .reset(reset), .din(SDA), .dout(sda_f));

  assign scl_rise = scl_f & ~scl_p_q;
  assign scl_fall = ~scl_f & scl_p_q;
  assign start    = ~sda_f & sda_p_q & scl_f;
  assign stop     = sda_f & ~sda_p_q & scl_f;

  always_comb begin
    shifted     = {sr_q[6:0], sda_f};
    ptr_inc     = (ptr_q == PTR_W'(NUM_BYTES - 1)) ? '0 : ptr_q + PTR_W'(1);
    rd_byte     = 8'd0;
    rd_byte_inc = 8'd0;
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (ptr_q == PTR_W'(k))   rd_byte     = IOin[8*k +: 8];
      if (ptr_inc == PTR_W'(k)) rd_byte_inc = IOin[8*k +: 8];
    end
  end

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    sda_oe_d = sda_oe_q;
    phase_d  = phase_q;
    rw_d     = rw_q;
    commit_d = 1'b0;
    io_d     = io_q;
    strobe_d = 1'b0;
    idx_d    = idx_q;
    busy_d   = busy_q;

    // A complete byte is committed the clk after its 8th rising edge, before the pointer moves on.
    if (commit_q) begin
      for (int k = 0; k < NUM_BYTES; k++)
        if (ptr_q == PTR_W'(k)) io_d[8*k +: 8] = sr_q;
      idx_d    = ptr_q;
      strobe_d = 1'b1;
    end

    if (start) begin
      state_d  = ADDR;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
      phase_d  = 1'b0;
    end else if (stop) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          sr_d  = shifted;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            if (shifted[7:1] == ADR) begin
              state_d = ADDR_ACK;
              rw_d    = shifted[0];
              busy_d  = 1'b1;
              phase_d = 1'b0;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end
        end
        // phase 0: pull SDA low after the 8th fall; phase 1: hand over after the 9th fall
        ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
          if (!phase_q) begin
            sda_oe_d = 1'b1;
            phase_d  = 1'b1;
          end else begin
            phase_d  = 1'b0;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
            if (state_q == ADDR_ACK && rw_q) begin
              state_d  = RDATA;
              sr_d     = rd_byte;
              sda_oe_d = ~rd_byte[7];
            end else if (state_q == ADDR_ACK) begin
              state_d = PTR;
            end else begin
              state_d = WDATA;
              if (state_q == WDATA_ACK) ptr_d = ptr_inc;
            end
          end
        end
        PTR: if (scl_rise) begin
          sr_d  = shifted;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            if (32'(shifted) < NUM_BYTES) begin
              ptr_d   = PTR_W'(shifted);
              state_d = PTR_ACK;
              phase_d = 1'b0;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end
        end
        WDATA: if (scl_rise) begin
          sr_d  = shifted;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            state_d  = WDATA_ACK;
            phase_d  = 1'b0;
            commit_d = 1'b1;
          end
        end
        RDATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              state_d  = RDATA_ACK;
              phase_d  = 1'b0;
            end else begin
              sr_d     = {sr_q[6:0], 1'b0};
              sda_oe_d = ~sr_q[6];
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise) begin
            if (!sda_f) begin
              phase_d = 1'b1;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end else if (scl_fall && phase_q) begin
            ptr_d    = ptr_inc;
            sr_d     = rd_byte_inc;
            sda_oe_d = ~rd_byte_inc[7];
            cnt_d    = 4'd0;
            phase_d  = 1'b0;
            state_d  = RDATA;
          end
        end
        default: busy_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      sr_q     <= 8'd0;
      cnt_q    <= 4'd0;
      ptr_q    <= '0;
      sda_oe_q <= 1'b0;
      phase_q  <= 1'b0;
      rw_q     <= 1'b0;
      commit_q <= 1'b0;
      io_q     <= '0;
      strobe_q <= 1'b0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      scl_p_q  <= 1'b1;
      sda_p_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      sda_oe_q <= sda_oe_d;
      phase_q  <= phase_d;
      rw_q     <= rw_d;
      commit_q <= commit_d;
      io_q     <= io_d;
      strobe_q <= strobe_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      scl_p_q  <= scl_f;
      sda_p_q  <= sda_f;
    end
  end

  assign SDA       = sda_oe_q ? 1'b0 : 1'bz;
  assign IOout     = io_q;
  assign wr_strobe = strobe_q;
  assign wr_index  = idx_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_i2c_slave_regbank.sv
// tb/tb_i2c_slave_regbank.sv - table, directed and randomized checks of i2c_slave_regbank
module tb_i2c_slave_regbank;
  localparam int N = 4;
  localparam int Q = 8;
  localparam logic [6:0] MY_ADR = 7'h10;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           scl = 1'b1;
  logic           m_sda_low = 1'b0;
  logic [8*N-1:0] io_in = '0;
  wire  [8*N-1:0] io_out;
  logic           wr_strobe;
  logic [3:0]     wr_index;
  logic           busy;
  wire            sda_bus;

  pullup (sda_bus);
  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_slave_regbank #(.NUM_BYTES(N), .PTR_W(4), .FILTER_LEN(3)) dut (
    .clk(clk), .reset(reset), .SCL(scl), .SDA(sda_bus), .ADR(MY_ADR),
    .IOin(io_in), .IOout(io_out), .wr_strobe(wr_strobe), .wr_index(wr_index), .busy(busy));

  typedef struct {
    logic [7:0]  addr_b;
    logic [7:0]  ptr_b;
    int          nd;
    logic [23:0] dat;
    logic        exp_aack;
    logic        exp_pack;
    logic        exp_dack;
    logic        exp_busy;
    logic [31:0] exp_io;
    int          exp_str;
    logic [3:0]  exp_idx;
  } vec_t;

  int         total = 0;
  int         bad = 0;
  int         strobe_cnt = 0;
  logic [3:0] last_idx = '0;
  logic       busy_seen = 1'b0;
  logic       sda_low_seen = 1'b0;
  logic       m_prev = 1'b0;
  logic [7:0] io_m [N];
  int         ptr_m;

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) begin
      strobe_cnt++;
      last_idx = wr_index;
    end
    if (busy === 1'b1) busy_seen = 1'b1;
    if (sda_bus === 1'b0 && !m_sda_low && !m_prev) sda_low_seen = 1'b1;
    m_prev = m_sda_low;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // gtype 1: 1-clk SCL high spike in the low phase; gtype 2: 1-clk low dip in the high phase
  task automatic bit_cycle(input logic b, input int gtype, output logic smp);
    m_sda_low = ~b;
    if (gtype == 1) begin
      wait_clk(Q/2); scl = 1'b1; wait_clk(1); scl = 1'b0; wait_clk(Q - Q/2 - 1);
    end else wait_clk(Q);
    scl = 1'b1;
    if (gtype == 2) begin
      wait_clk(Q/2); scl = 1'b0; wait_clk(1); scl = 1'b1; wait_clk(Q - Q/2 - 1);
    end else wait_clk(Q);
    smp = sda_bus;
    wait_clk(Q);
    scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic bus_start();
    m_sda_low = 1'b0; wait_clk(Q);
    scl = 1'b1;       wait_clk(Q);
    m_sda_low = 1'b1; wait_clk(Q);
    scl = 1'b0;       wait_clk(Q);
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1; wait_clk(Q);
    scl = 1'b1;       wait_clk(Q);
    m_sda_low = 1'b0; wait_clk(2*Q);
  endtask

  task automatic write_byte(input logic [7:0] b, input int gbit, input int gtype, output logic ack);
    logic smp;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], (i == gbit) ? gtype : 0, smp);
    bit_cycle(1'b1, 0, smp);
    ack = ~smp;
  endtask

  task automatic read_byte(input logic m_ack, output logic [7:0] d);
    logic smp;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, 0, smp);
      d[i] = smp;
    end
    bit_cycle(~m_ack, 0, smp);
  endtask

  function automatic logic [31:0] model_io();
    logic [31:0] v = '0;
    for (int k = N - 1; k >= 0; k--) v = (v << 8) | 32'(io_m[k]);
    return v;
  endfunction

  vec_t       vecs [4];
  logic       ack;
  logic [7:0] d, p;
  int         nd, exp_str, last_w;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h20, 8'h00, 1, 24'h00008E, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000008E, 1, 4'd0};
    vecs[1] = '{8'h2E, 8'h22, 0, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000008E, 0, 4'd0};
    vecs[2] = '{8'h20, 8'h03, 3, 24'hC3B2A1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hA100C3B2, 3, 4'd1};
    vecs[3] = '{8'h20, 8'h05, 1, 24'h000077, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA100C3B2, 0, 4'd0};

    wait_clk(4);
    check("reset io_out", io_out, 0);
    check("reset wr_strobe", wr_strobe, 0);
    check("reset wr_index", wr_index, 0);
    check("reset busy", busy, 0);
    check("reset sda", sda_bus, 1);
    reset = 1'b1;
    wait_clk(4);

    for (int i = 0; i < 4; i++) begin
      strobe_cnt = 0; busy_seen = 1'b0; sda_low_seen = 1'b0;
      bus_start();
      write_byte(vecs[i].addr_b, -1, 0, ack);
      check($sformatf("v%0d addr_ack", i), ack, vecs[i].exp_aack);
      write_byte(vecs[i].ptr_b, -1, 0, ack);
      check($sformatf("v%0d ptr_ack", i), ack, vecs[i].exp_pack);
      for (int j = 0; j < vecs[i].nd; j++) begin
        write_byte(8'(vecs[i].dat >> (8*j)), -1, 0, ack);
        check($sformatf("v%0d data%0d_ack", i, j), ack, vecs[i].exp_dack);
      end
      bus_stop();
      check($sformatf("v%0d io_out", i), io_out, vecs[i].exp_io);
      check($sformatf("v%0d strobes", i), strobe_cnt, vecs[i].exp_str);
      check($sformatf("v%0d busy_after", i), busy, 0);
      check($sformatf("v%0d busy_seen", i), busy_seen, vecs[i].exp_busy);
      check($sformatf("v%0d sda_driven", i), sda_low_seen, vecs[i].exp_aack);
      if (vecs[i].exp_str > 0) check($sformatf("v%0d wr_index", i), last_idx, vecs[i].exp_idx);
    end

    // combined read with repeated START, then a read that relies on the persisted pointer
    io_in = 32'h44332211;
    bus_start();
    write_byte(8'h20, -1, 0, ack); check("rd addr_w_ack", ack, 1);
    write_byte(8'h01, -1, 0, ack); check("rd ptr_ack", ack, 1);
    bus_start();
    write_byte(8'h21, -1, 0, ack); check("rd addr_r_ack", ack, 1);
    read_byte(1'b1, d); check("rd byte0", d, 8'h22);
    read_byte(1'b1, d); check("rd byte1", d, 8'h33);
    read_byte(1'b0, d); check("rd byte2", d, 8'h44);
    bus_stop();
    check("rd busy_after", busy, 0);
    bus_start();
    write_byte(8'h21, -1, 0, ack); check("rd2 addr_ack", ack, 1);
    read_byte(1'b0, d); check("rd2 ptr_persist", d, 8'h44);
    bus_stop();

    // SCL glitches inside data bits must not disturb the byte
    strobe_cnt = 0;
    bus_start();
    write_byte(8'h20, -1, 0, ack); check("gl addr_ack", ack, 1);
    write_byte(8'h00, -1, 0, ack); check("gl ptr_ack", ack, 1);
    write_byte(8'h3C, 4, 1, ack);  check("gl data0_ack", ack, 1);
    write_byte(8'hC5, 2, 2, ack);  check("gl data1_ack", ack, 1);
    bus_stop();
    check("gl io_out", io_out, 32'hA100C53C);
    check("gl strobes", strobe_cnt, 2);
    check("gl wr_index", last_idx, 1);

    // reset in the middle of a write byte
    bus_start();
    write_byte(8'h20, -1, 0, ack); check("rst addr_ack", ack, 1);
    write_byte(8'h02, -1, 0, ack); check("rst ptr_ack", ack, 1);
    for (int i = 7; i >= 4; i--) bit_cycle(d[0] | 1'b1 ? 1'(8'h5A >> i) : 1'b0, 0, ack);
    reset = 1'b0;
    wait_clk(3);
    check("rst sda", sda_bus, 1);
    check("rst io_out", io_out, 0);
    check("rst busy", busy, 0);
    check("rst wr_index", wr_index, 0);
    reset = 1'b1;
    m_sda_low = 1'b0;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(2*Q);
    strobe_cnt = 0;
    bus_start();
    write_byte(8'h20, -1, 0, ack); check("post addr_ack", ack, 1);
    write_byte(8'h02, -1, 0, ack); check("post ptr_ack", ack, 1);
    write_byte(8'h5A, -1, 0, ack); check("post data_ack", ack, 1);
    bus_stop();
    check("post io_out", io_out, 32'h005A0000);
    check("post strobes", strobe_cnt, 1);
    check("post wr_index", last_idx, 2);

    // randomized transactions against an abstract register/pointer model
    for (int k = 0; k < N; k++) io_m[k] = 8'h00;
    io_m[2] = 8'h5A;
    ptr_m = 3;
    for (int t = 0; t < 16; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        p  = 8'($urandom_range(0, 5));
        nd = $urandom_range(1, 3);
        strobe_cnt = 0; exp_str = 0; last_w = 0;
        bus_start();
        write_byte(8'h20, -1, 0, ack); check($sformatf("r%0d w addr_ack", t), ack, 1);
        write_byte(p, -1, 0, ack);     check($sformatf("r%0d w ptr_ack", t), ack, int'(p) < N);
        if (int'(p) < N) ptr_m = int'(p);
        for (int j = 0; j < nd; j++) begin
          d = 8'($urandom);
          write_byte(d, -1, 0, ack);
          check($sformatf("r%0d w data%0d_ack", t, j), ack, int'(p) < N);
          if (int'(p) < N) begin
            io_m[ptr_m] = d;
            last_w = ptr_m;
            ptr_m = (ptr_m + 1) % N;
            exp_str++;
          end
        end
        bus_stop();
        check($sformatf("r%0d w io_out", t), io_out, model_io());
        check($sformatf("r%0d w strobes", t), strobe_cnt, exp_str);
        if (exp_str > 0) check($sformatf("r%0d w wr_index", t), last_idx, last_w);
      end else begin
        io_in = $urandom;
        if ($urandom_range(0, 1) == 1) begin
          p = 8'($urandom_range(0, N - 1));
          bus_start();
          write_byte(8'h20, -1, 0, ack); check($sformatf("r%0d rp addr_ack", t), ack, 1);
          write_byte(p, -1, 0, ack);     check($sformatf("r%0d rp ptr_ack", t), ack, 1);
          ptr_m = int'(p);
        end
        bus_start();
        write_byte(8'h21, -1, 0, ack); check($sformatf("r%0d r addr_ack", t), ack, 1);
        nd = $urandom_range(1, 3);
        for (int j = 0; j < nd; j++) begin
          read_byte(j != nd - 1, d);
          check($sformatf("r%0d r byte%0d", t, j), d, 8'(io_in >> (8*ptr_m)));
          if (j != nd - 1) ptr_m = (ptr_m + 1) % N;
        end
        bus_stop();
        check($sformatf("r%0d r busy_after", t), busy, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
